// File: rtl/prog_loader.sv
// prog_loader: loads a program image from a byte stream into CPU program
// memory, holds the CPU in reset during the load plus RST_HOLD cycles, and
// then releases it.
//
// State table
//   state  | meaning
//   IDLE   | waiting for start, CPU held in reset
//   LOAD   | accepting bytes, one memory write per accepted byte
//   HOLD   | last byte accepted, CPU still in reset for RST_HOLD more cycles
//   RUN    | CPU released, halt is watched, start reloads
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i, len_i        load request and byte count minus one
//   in_valid_i, in_data_i byte source, in_ready_o handshake back
//   mem_wr_o, mem_addr_o, mem_data_o  registered program-memory write
//   cpu_rst_o, halt_i     CPU reset out, CPU halt flag in
//   busy_o, done_o, halted_o  status
module prog_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int RST_HOLD   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  mem_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  cpu_rst_o,
  input  logic                  halt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  halted_o
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   len_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [HW-1:0]           hold_cnt_q;
  logic                    in_ready_q;
  logic                    mem_wr_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_data_q;
  logic                    cpu_rst_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    halted_q;
  logic                    accept;

  // in_ready_q is only ever high in LOAD
  assign accept = in_ready_q & in_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      in_ready_q <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      mem_wr_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_LOAD;
            len_q      <= len_i;
            ptr_q      <= '0;
            halted_q   <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (accept) begin
            mem_wr_q   <= 1'b1;
            mem_addr_q <= ptr_q;
            mem_data_q <= in_data_i;
            if (ptr_q == len_q) begin
              // pointer parks on the last address, so it never wraps
              state_q    <= S_HOLD;
              in_ready_q <= 1'b0;
              hold_cnt_q <= HOLD_INIT;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          // counting down to zero and then one more edge puts the release
          // RST_HOLD+1 edges after the final accept, after its write cycle
          if (hold_cnt_q == '0) begin
            state_q   <= S_RUN;
            cpu_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end
        end
        S_RUN: begin
          if (start_i) begin
            state_q    <= S_LOAD;
            len_q      <= len_i;
            ptr_q      <= '0;
            halted_q   <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            cpu_rst_q  <= 1'b1;
          end else if (halt_i) begin
            halted_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o = in_ready_q;
  assign mem_wr_o   = mem_wr_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign cpu_rst_o  = cpu_rst_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign halted_o   = halted_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: expected memory writes are queued as bytes are
// driven, observed writes are captured at the falling edge and each scenario
// task pairs the two queues once its load has finished.
module tb_prog_loader;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int RH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          halt = 1'b0;
  logic          in_ready, mem_wr, cpu_rst, busy, done, halted;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RST_HOLD(RH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
    .cpu_rst_o(cpu_rst), .halt_i(halt), .busy_o(busy), .done_o(done),
    .halted_o(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  wr_count = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      wr_count = wr_count + 1;
      obs_q.push_back('{a: mem_addr, d: mem_data, cyc: cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int a, input logic [DW-1:0] d);
    exp_q.push_back('{a: AW'(a), d: d, cyc: 0});
  endtask

  task automatic test_reset();
    logic [18:0] got;
    logic [18:0] rst_vec;
    int w0;
    wr_t e, o;
    rst_vec = {1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    #2 rst = 1'b1;
    @(negedge clk);
    got = {in_ready, mem_wr, mem_addr, mem_data, cpu_rst, busy, done, halted};
    vectors++;
    if (got !== rst_vec) begin
      miscompares++;
      $display("FAIL reset_state got=%h expected=%h", got, rst_vec);
    end
    tick(); rst = 1'b0;
    tick();
    start = 1'b1; len = 5; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; push_exp(0, 8'h11); tick();
    in_data = 8'h22; push_exp(1, 8'h22); tick();
    in_data = 8'h33;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    got = {in_ready, mem_wr, mem_addr, mem_data, cpu_rst, busy, done, halted};
    vectors++;
    if (got !== rst_vec) begin
      miscompares++;
      $display("FAIL reset_mid_load got=%h expected=%h", got, rst_vec);
    end
    w0 = wr_count;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (wr_count !== w0) begin
      miscompares++;
      $display("FAIL reset_no_write got=%0d writes expected=0", wr_count - w0);
    end
    got = {in_ready, mem_wr, mem_addr, mem_data, cpu_rst, busy, done, halted};
    vectors++;
    if (got !== rst_vec) begin
      miscompares++;
      $display("FAIL reset_idle_after got=%h expected=%h", got, rst_vec);
    end
    in_valid = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL reset_wr missing: got none expected addr=%0d data=%h", e.a, e.d);
      end else begin
        o = obs_q.pop_front();
        if (o.a !== e.a || o.d !== e.d) begin
          miscompares++;
          $display("FAIL reset_wr got addr=%0d data=%h expected addr=%0d data=%h", o.a, o.d, e.a, e.d);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_wr_extra got=%0d extra expected=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] b [3];
    logic [2:0] got, want;
    wr_t e, o;
    int c0, n;
    b[0] = 8'hA2; b[1] = 8'h1F; b[2] = 8'h00;
    start = 1'b1; len = 2; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = b[i]; push_exp(i, b[i]); tick();
    end
    in_valid = 1'b0;
    got = {busy, cpu_rst, in_ready};
    vectors++;
    if (got !== 3'b110) begin
      miscompares++;
      $display("FAIL basic_hold_entry got=%b expected=110", got);
    end
    for (int k = 1; k <= RH + 2; k++) begin
      tick();
      want = {(k <= RH), (k <= RH), (k == RH + 1)};
      got = {cpu_rst, busy, done};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL basic_release edge+%0d got=%b expected=%b", k, got, want);
      end
    end
    n = 0; c0 = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL basic_wr missing: got none expected addr=%0d data=%h", e.a, e.d);
      end else begin
        o = obs_q.pop_front();
        if (n == 0) c0 = o.cyc;
        if (o.a !== e.a || o.d !== e.d || o.cyc != c0 + n) begin
          miscompares++;
          $display("FAIL basic_wr got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                   o.a, o.d, o.cyc, e.a, e.d, c0 + n);
        end
      end
      n++;
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_wr_extra got=%0d extra expected=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_gap();
    wr_t e, o;
    start = 1'b1; len = 1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'h5C; push_exp(0, 8'h5C); tick();
    in_valid = 1'b0; in_data = 8'hEE;
    for (int g = 0; g < 3; g++) begin
      tick();
      vectors++;
      if (mem_wr !== 1'b0) begin
        miscompares++;
        $display("FAIL gap_no_write cycle %0d got mem_wr=%b expected=0", g, mem_wr);
      end
    end
    in_valid = 1'b1; in_data = 8'h3E; push_exp(1, 8'h3E); tick();
    in_valid = 1'b0;
    for (int k = 0; k < 20 && cpu_rst !== 1'b0; k++) tick();
    vectors++;
    if (cpu_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_release_timeout got cpu_rst=%b expected=0", cpu_rst);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL gap_wr missing: got none expected addr=%0d data=%h", e.a, e.d);
      end else begin
        o = obs_q.pop_front();
        if (o.a !== e.a || o.d !== e.d) begin
          miscompares++;
          $display("FAIL gap_wr got addr=%0d data=%h expected addr=%0d data=%h", o.a, o.d, e.a, e.d);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL gap_wr_extra got=%0d extra expected=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_long();
    wr_t e, o;
    logic [DW-1:0] d;
    start = 1'b1; len = 31; tick(); start = 1'b0;
    for (int i = 0; i < 33; i++) begin
      d = DW'($urandom_range(0, 255));
      in_valid = 1'b1; in_data = d;
      if (i < 32) begin
        push_exp(i, d);
      end else begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL long_33rd_ready got in_ready=%b expected=0", in_ready);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && cpu_rst !== 1'b0; k++) tick();
    vectors++;
    if (cpu_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL long_release_timeout got cpu_rst=%b expected=0", cpu_rst);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL long_wr missing: got none expected addr=%0d data=%h", e.a, e.d);
      end else begin
        o = obs_q.pop_front();
        if (o.a !== e.a || o.d !== e.d) begin
          miscompares++;
          $display("FAIL long_wr got addr=%0d data=%h expected addr=%0d data=%h", o.a, o.d, e.a, e.d);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL long_wr_extra got=%0d extra expected=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    wr_t e, o;
    logic [2:0] got;
    start = 1'b1; len = 3; tick(); start = 1'b0;
    got = {cpu_rst, busy, in_ready};
    vectors++;
    if (got !== 3'b111) begin
      miscompares++;
      $display("FAIL restart_from_run got=%b expected=111", got);
    end
    in_valid = 1'b1; in_data = 8'hC0; push_exp(0, 8'hC0); tick();
    in_valid = 1'b0; start = 1'b1; len = 0; tick(); start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      in_valid = 1'b1; in_data = DW'(8'hC0 + i); push_exp(i, DW'(8'hC0 + i)); tick();
    end
    in_valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 20 && cpu_rst !== 1'b0; k++) tick();
    vectors++;
    if (cpu_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_release_timeout got cpu_rst=%b expected=0", cpu_rst);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL restart_wr missing: got none expected addr=%0d data=%h", e.a, e.d);
      end else begin
        o = obs_q.pop_front();
        if (o.a !== e.a || o.d !== e.d) begin
          miscompares++;
          $display("FAIL restart_wr got addr=%0d data=%h expected addr=%0d data=%h", o.a, o.d, e.a, e.d);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL restart_wr_extra got=%0d extra expected=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_halt();
    wr_t e, o;
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_initial got=%b expected=0", halted);
    end
    halt = 1'b1; tick(); halt = 1'b0;
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_set got=%b expected=1", halted);
    end
    tick(); tick();
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_sticky got=%b expected=1", halted);
    end
    start = 1'b1; len = 0; tick(); start = 1'b0;
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_clear got=%b expected=0", halted);
    end
    in_valid = 1'b1; in_data = 8'h77; push_exp(0, 8'h77); tick();
    in_valid = 1'b0;
    for (int k = 0; k < 20 && cpu_rst !== 1'b0; k++) tick();
    vectors++;
    if (cpu_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_release_timeout got cpu_rst=%b expected=0", cpu_rst);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL halt_wr missing: got none expected addr=%0d data=%h", e.a, e.d);
      end else begin
        o = obs_q.pop_front();
        if (o.a !== e.a || o.d !== e.d) begin
          miscompares++;
          $display("FAIL halt_wr got addr=%0d data=%h expected addr=%0d data=%h", o.a, o.d, e.a, e.d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_long();
    test_back_to_back();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
